// File: rtl/ssd_reader.sv
// Seven-segment bus reader: recovers per-position digit codes from a multiplexed display; SSD_READER_HEX_EN adds A-F glyphs.
// Latency: capture registered STABLE_CYCLES+1 edges after the bus settles on a new pattern/position.
// Backpressure: none; the bus is sampled every cycle and results are overwritten in place.
module ssd_reader #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                err_clr,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dvalid,
    output logic                upd,
    output logic                err,
    output logic                err_sticky,
    output logic                frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cnt;
    logic [7:0]         cnt_nxt;
    logic [6:0]         seg_q;
    logic [NDIG-1:0]    sel_q;
    logic [NDIG-1:0]    mask;

    logic               sel_ok;
    logic               changed;
    logic               capture;
    logic               legal;
    logic [3:0]         code;
    logic [NDIG-1:0]    mask_set;

    logic [4*NDIG-1:0]  digits_nxt;
    logic [NDIG-1:0]    dvalid_nxt;
    logic [NDIG-1:0]    mask_nxt;
    logic               upd_nxt;
    logic               err_nxt;
    logic               sticky_nxt;
    logic               frame_nxt;

    // Returns {legal, code}; blank and any non-glyph pattern are illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h7E: r = {1'b1, 4'h0};
            7'h30: r = {1'b1, 4'h1};
            7'h6D: r = {1'b1, 4'h2};
            7'h79: r = {1'b1, 4'h3};
            7'h33: r = {1'b1, 4'h4};
            7'h5B: r = {1'b1, 4'h5};
            7'h5F: r = {1'b1, 4'h6};
            7'h70: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h7B: r = {1'b1, 4'h9};
`ifdef SSD_READER_HEX_EN
            7'h77: r = {1'b1, 4'hA};
            7'h1F: r = {1'b1, 4'hB};
            7'h4E: r = {1'b1, 4'hC};
            7'h3D: r = {1'b1, 4'hD};
            7'h4F: r = {1'b1, 4'hE};
            7'h47: r = {1'b1, 4'hF};
`else
            7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47: r = 5'h00;
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        sel_ok  = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
        changed = (seg != seg_q) || (dig_sel != sel_q);
        {legal, code} = decode(seg_q);
    end

    // Stability FSM: any change restarts the count; capture fires once per settled pattern.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (!sel_ok) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
        end else if (changed) begin
            state_nxt = SETTLE;
            cnt_nxt   = 8'd0;
        end else if (state == SETTLE) begin
            if (cnt == CNT_LAST) begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            seg_q <= 7'd0;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            seg_q <= seg;
            sel_q <= dig_sel;
        end
    end

    always_comb begin
        digits_nxt = digits;
        dvalid_nxt = dvalid;
        mask_nxt   = mask;
        mask_set   = mask | sel_q;
        upd_nxt    = 1'b0;
        err_nxt    = 1'b0;
        frame_nxt  = 1'b0;
        sticky_nxt = err_clr ? 1'b0 : err_sticky;
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel_q[i]) begin
                    if (legal) begin
                        digits_nxt[4*i +: 4] = code;
                    end
                    dvalid_nxt[i] = legal;
                end
            end
            upd_nxt = legal;
            err_nxt = !legal;
            // A new error overrides a simultaneous clear.
            if (!legal) begin
                sticky_nxt = 1'b1;
            end
            if (&mask_set) begin
                frame_nxt = 1'b1;
                mask_nxt  = '0;
            end else begin
                mask_nxt  = mask_set;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits     <= '0;
            dvalid     <= '0;
            mask       <= '0;
            upd        <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            digits     <= digits_nxt;
            dvalid     <= dvalid_nxt;
            mask       <= mask_nxt;
            upd        <= upd_nxt;
            err        <= err_nxt;
            err_sticky <= sticky_nxt;
            frame_done <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_reader.sv
// Directed bench for ssd_reader with a capture scoreboard checked by a monitor process.
module tb_ssd_reader;

    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        seg = 7'h00;
    logic [NDIG-1:0]   dig_sel = '0;
    logic              err_clr = 1'b0;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dvalid;
    logic              upd;
    logic              err;
    logic              err_sticky;
    logic              frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       is_err;
        int         pos;
        logic [3:0] code;
        logic       frame;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [6:0] pat[4];

    ssd_reader #(.NDIG(NDIG), .STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .err_clr    (err_clr),
        .digits     (digits),
        .dvalid     (dvalid),
        .upd        (upd),
        .err        (err),
        .err_sticky (err_sticky),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic is_err, input int pos, input logic [3:0] code, input logic frame);
        exp_t e;
        e.is_err = is_err;
        e.pos    = pos;
        e.code   = code;
        e.frame  = frame;
        sb.push_back(e);
    endtask

    // Every capture pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (upd || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_capture", {30'd0, upd, err}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("cap_err", {31'd0, err}, {31'd0, mon_e.is_err});
                    chk("cap_upd", {31'd0, upd}, {31'd0, !mon_e.is_err});
                    chk("cap_frame", {31'd0, frame_done}, {31'd0, mon_e.frame});
                    if (!mon_e.is_err) begin
                        chk("cap_code", {28'd0, digits[4*mon_e.pos +: 4]}, {28'd0, mon_e.code});
                        chk("cap_dvalid", {31'd0, dvalid[mon_e.pos]}, 32'd1);
                    end else begin
                        chk("err_dvalid", {31'd0, dvalid[mon_e.pos]}, 32'd0);
                        chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
                    end
                end
            end else begin
                chk("stray_frame", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    initial begin
        pat[0] = 7'h7E;
        pat[1] = 7'h30;
        pat[2] = 7'h6D;
        pat[3] = 7'h79;

        // Reset state
        tick(2);
        chk("rst_digits", {16'd0, digits}, 32'd0);
        chk("rst_dvalid", {28'd0, dvalid}, 32'd0);
        chk("rst_pulses", {29'd0, upd, err, frame_done}, 32'd0);
        chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Single digit '2' on position 0, capture exactly at edge 5
        dig_sel = 4'b0001;
        seg     = 7'h6D;
        push(1'b0, 0, 4'h2, 1'b0);
        tick(4);
        chk("t1_early", {31'd0, upd}, 32'd0);
        tick(1);
        chk("t1_upd", {31'd0, upd}, 32'd1);
        chk("t1_digit", {28'd0, digits[3:0]}, 32'h2);
        tick(1);
        chk("t1_once", {31'd0, upd}, 32'd0);
        tick(3);

        // Toggle 1 -> 3 before capture: only 3 is captured, 5 edges after the toggle
        seg = 7'h30;
        tick(2);
        seg = 7'h79;
        push(1'b0, 0, 4'h3, 1'b0);
        tick(4);
        chk("t2_early", {31'd0, upd}, 32'd0);
        tick(1);
        chk("t2_upd", {31'd0, upd}, 32'd1);
        chk("t2_digit", {28'd0, digits[3:0]}, 32'h3);
        tick(2);

        // Scan all positions; last capture completes the frame
        for (int p = 0; p < NDIG; p++) begin
            dig_sel = 4'(1 << p);
            seg     = pat[p];
            push(1'b0, p, 4'(p), p == NDIG - 1);
            tick(4);
            chk("scan_early", {31'd0, upd}, 32'd0);
            tick(1);
            chk("scan_upd", {31'd0, upd}, 32'd1);
            chk("scan_frame", {31'd0, frame_done}, (p == NDIG - 1) ? 32'd1 : 32'd0);
            tick(1);
        end
        chk("scan_digits", {16'd0, digits}, 32'h3210);
        chk("scan_dvalid", {28'd0, dvalid}, 32'hF);

        // Hex glyph 'A' on position 1
        dig_sel = 4'b0010;
        seg     = 7'h77;
`ifdef SSD_READER_HEX_EN
        push(1'b0, 1, 4'hA, 1'b0);
        tick(5);
        chk("hex_upd", {31'd0, upd}, 32'd1);
        chk("hex_err", {31'd0, err}, 32'd0);
        chk("hex_digit", {28'd0, digits[7:4]}, 32'hA);
        chk("hex_dvalid", {28'd0, dvalid}, 32'hF);
`else
        push(1'b1, 1, 4'h0, 1'b0);
        tick(5);
        chk("hex_err", {31'd0, err}, 32'd1);
        chk("hex_sticky", {31'd0, err_sticky}, 32'd1);
        chk("hex_digit_kept", {28'd0, digits[7:4]}, 32'h1);
        chk("hex_dvalid", {28'd0, dvalid}, 32'hD);
`endif
        tick(1);
        chk("hex_once", {30'd0, upd, err}, 32'd0);

        // Non-one-hot select: never captures
        dig_sel = 4'b0011;
        seg     = 7'h7F;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) err_clr = 1'b1;
            tick(1);
            err_clr = 1'b0;
            chk("multi_nocap", {30'd0, upd, err}, 32'd0);
        end
        chk("clr_sticky", {31'd0, err_sticky}, 32'd0);

        // Blank on position 2 with err_clr on the capture edge: set wins
        dig_sel = 4'b0100;
        seg     = 7'h00;
        push(1'b1, 2, 4'h0, 1'b0);
        tick(4);
        chk("blank_early", {31'd0, err}, 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("blank_err", {31'd0, err}, 32'd1);
        chk("blank_sticky", {31'd0, err_sticky}, 32'd1);
        tick(1);
        chk("blank_err_once", {31'd0, err}, 32'd0);
        chk("sticky_hold", {31'd0, err_sticky}, 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("sticky_clear", {31'd0, err_sticky}, 32'd0);

        // Reset at edge 3 of a count, then a full fresh count
        dig_sel = 4'b1000;
        seg     = 7'h7F;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_digits", {16'd0, digits}, 32'd0);
        chk("mid_rst_dvalid", {28'd0, dvalid}, 32'd0);
        chk("mid_rst_flags", {28'd0, upd, err, err_sticky, frame_done}, 32'd0);
        rst = 1'b0;
        push(1'b0, 3, 4'h8, 1'b0);
        tick(4);
        chk("post_rst_early", {31'd0, upd}, 32'd0);
        tick(1);
        chk("post_rst_upd", {31'd0, upd}, 32'd1);
        chk("post_rst_digits", {16'd0, digits}, 32'h8000);
        chk("post_rst_dvalid", {28'd0, dvalid}, 32'h8);
        tick(4);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
